// File: rtl/nla_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// nla_arbiter - round-robin arbiter sharing one NLA engine among N_REQ clients
// Revision: 1.0
// ----------------------------------------------------------------------------
module nla_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 16,
  parameter int FUNC_W  = 2,
  parameter int TIMEOUT = 64,
  localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_REQ-1:0]         req_valid_i,
  output logic [N_REQ-1:0]         req_ready_o,
  input  logic [N_REQ*DATA_W-1:0]  req_data_i,
  input  logic [N_REQ*FUNC_W-1:0]  req_func_i,
  output logic                     eng_cfg_o,
  output logic [FUNC_W-1:0]        eng_cfg_func_o,
  input  logic                     eng_cfg_done_i,
  output logic                     eng_start_o,
  output logic [DATA_W-1:0]        eng_data_o,
  input  logic                     eng_done_i,
  input  logic [DATA_W-1:0]        eng_result_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [ID_W-1:0]          rsp_id_o,
  output logic [DATA_W-1:0]        rsp_data_o,
  output logic                     rsp_err_o
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CFG, S_CFG_WAIT, S_ISSUE, S_WAIT, S_RESP
  } state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [FUNC_W-1:0]   func_q, func_d;
  logic                bank_vld_q, bank_vld_d;
  logic [FUNC_W-1:0]   loaded_func_q, loaded_func_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;

  logic [2*N_REQ-1:0]  req_dbl;
  logic [N_REQ-1:0]    req_rot;
  logic                gnt_any;
  logic [ID_W-1:0]     gnt_off, gnt_id;
  logic [ID_W:0]       gnt_sum;
  logic [DATA_W-1:0]   sel_data;
  logic [FUNC_W-1:0]   sel_func;
  logic [CNT_W-1:0]    cnt_inc;

  // Rotating the doubled vector puts rr_ptr at bit 0, so the lowest set bit wins.
  assign req_dbl = {req_valid_i, req_valid_i};
  assign req_rot = req_dbl[rr_ptr_q +: N_REQ];
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    gnt_any  = 1'b0;
    gnt_off  = '0;
    sel_data = '0;
    sel_func = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!gnt_any && req_rot[j]) begin
        gnt_any = 1'b1;
        gnt_off = ID_W'(j);
      end
    end
    gnt_sum = {1'b0, rr_ptr_q} + {1'b0, gnt_off};
    if (gnt_sum >= (ID_W+1)'(N_REQ)) begin
      gnt_sum = gnt_sum - (ID_W+1)'(N_REQ);
    end
    gnt_id = gnt_sum[ID_W-1:0];
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt_id == ID_W'(k)) begin
        sel_data = req_data_i[k*DATA_W +: DATA_W];
        sel_func = req_func_i[k*FUNC_W +: FUNC_W];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    id_d          = id_q;
    data_d        = data_q;
    func_d        = func_q;
    bank_vld_d    = bank_vld_q;
    loaded_func_d = loaded_func_q;
    cnt_d         = cnt_q;
    rsp_data_d    = rsp_data_q;
    rsp_err_d     = rsp_err_q;
    req_ready_o   = '0;
    case (state_q)
      S_IDLE: begin
        if (gnt_any) begin
          req_ready_o = N_REQ'(1) << gnt_id;
          id_d        = gnt_id;
          data_d      = sel_data;
          func_d      = sel_func;
          state_d     = (!bank_vld_q || (sel_func != loaded_func_q)) ? S_CFG : S_ISSUE;
        end
      end
      S_CFG: state_d = S_CFG_WAIT;
      S_CFG_WAIT: begin
        if (eng_cfg_done_i) begin
          loaded_func_d = func_q;
          bank_vld_d    = 1'b1;
          state_d       = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A result arriving on the abort cycle is still delivered.
        if (eng_done_i) begin
          rsp_data_d = eng_result_i;
          rsp_err_d  = 1'b0;
          state_d    = S_RESP;
        end else if (cnt_inc == CNT_W'(TIMEOUT-1)) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          bank_vld_d = 1'b0;
          state_d    = S_RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          rr_ptr_d = (id_q == ID_W'(N_REQ-1)) ? '0 : id_q + ID_W'(1);
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (rst_i) begin
      req_ready_o = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      id_q          <= '0;
      data_q        <= '0;
      func_q        <= '0;
      bank_vld_q    <= 1'b0;
      loaded_func_q <= '0;
      cnt_q         <= '0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      id_q          <= id_d;
      data_q        <= data_d;
      func_q        <= func_d;
      bank_vld_q    <= bank_vld_d;
      loaded_func_q <= loaded_func_d;
      cnt_q         <= cnt_d;
      rsp_data_q    <= rsp_data_d;
      rsp_err_q     <= rsp_err_d;
    end
  end

  assign eng_cfg_o      = (state_q == S_CFG);
  assign eng_cfg_func_o = func_q;
  assign eng_start_o    = (state_q == S_ISSUE);
  assign eng_data_o     = data_q;
  assign rsp_valid_o    = (state_q == S_RESP);
  assign rsp_id_o       = id_q;
  assign rsp_data_o     = rsp_data_q;
  assign rsp_err_o      = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_nla_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_nla_arbiter - directed self-checking bench for nla_arbiter
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_nla_arbiter;
  localparam int N_REQ = 4, DATA_W = 16, FUNC_W = 2, TIMEOUT = 16, ID_W = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst_i;
  logic [N_REQ-1:0]        req_valid_i, req_ready_o;
  logic [N_REQ*DATA_W-1:0] req_data_i;
  logic [N_REQ*FUNC_W-1:0] req_func_i;
  logic                    eng_cfg_o, eng_cfg_done_i, eng_start_o, eng_done_i;
  logic [FUNC_W-1:0]       eng_cfg_func_o;
  logic [DATA_W-1:0]       eng_data_o, eng_result_i, rsp_data_o;
  logic                    rsp_valid_o, rsp_ready_i, rsp_err_o;
  logic [ID_W-1:0]         rsp_id_o;

  nla_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .FUNC_W(FUNC_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_data_i(req_data_i), .req_func_i(req_func_i),
    .eng_cfg_o(eng_cfg_o), .eng_cfg_func_o(eng_cfg_func_o), .eng_cfg_done_i(eng_cfg_done_i),
    .eng_start_o(eng_start_o), .eng_data_o(eng_data_o),
    .eng_done_i(eng_done_i), .eng_result_i(eng_result_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_id_o(rsp_id_o), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Engine control, written only by the main sequence
  int              cfg_lat = 3;
  int              done_lat = 12;
  bit              done_en = 1'b1;
  logic [DATA_W-1:0] res_key = 16'hA5A5;
  int              inj_req = 0;

  // Engine model: acts at negedge+1
  initial begin : engine
    int cfg_cd;
    int done_cd;
    int inj_seen;
    logic [DATA_W-1:0] pend_res;
    cfg_cd = 0; done_cd = 0; inj_seen = 0; pend_res = '0;
    eng_cfg_done_i = 1'b0; eng_done_i = 1'b0; eng_result_i = '0;
    forever begin
      @(negedge clk); #1;
      eng_cfg_done_i = 1'b0;
      eng_done_i     = 1'b0;
      if (rst_i) begin cfg_cd = 0; done_cd = 0; end
      if (cfg_cd > 0) begin
        cfg_cd--;
        if (cfg_cd == 0) eng_cfg_done_i = 1'b1;
      end
      if (done_cd > 0) begin
        done_cd--;
        if (done_cd == 0) begin eng_done_i = 1'b1; eng_result_i = pend_res; end
      end
      if (inj_req != inj_seen) begin
        inj_seen = inj_req; eng_done_i = 1'b1; eng_result_i = 16'hDEAD;
      end
      if (eng_cfg_o) cfg_cd = cfg_lat;
      if (eng_start_o && done_en) begin done_cd = done_lat; pend_res = eng_data_o ^ res_key; end
    end
  end

  // Monitor: samples at negedge+3
  int cyc_n = 0, n_grant = 0, n_cfg = 0, n_start = 0, n_rsp = 0;
  int start_cyc = 0, rsp_first_cyc = 0;
  logic [FUNC_W-1:0] last_cfg_func = '0;
  logic [DATA_W-1:0] last_start_data = '0;
  logic prev_rv = 1'b0;
  int gnt_id_q[$];
  int gnt_cyc_q[$];
  logic [N_REQ-1:0] gnt_vec_q[$];
  int hs_cyc_q[$];
  int rsp_id_q[$];
  logic [DATA_W-1:0] rsp_data_q[$];
  logic rsp_err_q[$];

  always begin
    @(negedge clk); #3;
    cyc_n++;
    if (!rst_i) begin
      if (req_ready_o != '0) begin
        int id;
        id = 0;
        for (int k = 0; k < N_REQ; k++) if (req_ready_o[k]) id = k;
        gnt_id_q.push_back(id); gnt_cyc_q.push_back(cyc_n); gnt_vec_q.push_back(req_ready_o);
        n_grant++;
      end
      if (eng_cfg_o) begin n_cfg++; last_cfg_func = eng_cfg_func_o; end
      if (eng_start_o) begin n_start++; last_start_data = eng_data_o; start_cyc = cyc_n; end
      if (rsp_valid_o && !prev_rv) rsp_first_cyc = cyc_n;
      if (rsp_valid_o && rsp_ready_i) begin
        n_rsp++; hs_cyc_q.push_back(cyc_n);
        rsp_id_q.push_back(int'(rsp_id_o)); rsp_data_q.push_back(rsp_data_o); rsp_err_q.push_back(rsp_err_o);
      end
    end
    prev_rv = rsp_valid_o;
  end

  task automatic cyc();
    @(negedge clk); #2;
  endtask

  task automatic set_req(input int k, input logic [FUNC_W-1:0] f, input logic [DATA_W-1:0] d);
    req_func_i[k*FUNC_W +: FUNC_W] = f;
    req_data_i[k*DATA_W +: DATA_W] = d;
  endtask

  task automatic run_until_rsp(input int target, input int drop_at, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      cyc();
      if (n_grant >= drop_at) req_valid_i = '0;
      if (n_rsp >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    req_valid_i = 4'b1111;
    cyc(); cyc();
    n_checks++;
    if ({req_ready_o, rsp_valid_o} !== '0) begin
      n_fail++; $display("FAIL reset_handshake: got %h expected 0", {req_ready_o, rsp_valid_o});
    end
    n_checks++;
    if ({eng_cfg_o, eng_cfg_func_o, eng_start_o, eng_data_o} !== '0) begin
      n_fail++; $display("FAIL reset_engine: got %h expected 0", {eng_cfg_o, eng_cfg_func_o, eng_start_o, eng_data_o});
    end
    n_checks++;
    if ({rsp_id_o, rsp_data_o, rsp_err_o} !== '0) begin
      n_fail++; $display("FAIL reset_rsp: got %h expected 0", {rsp_id_o, rsp_data_o, rsp_err_o});
    end
    req_valid_i = '0;
    rst_i = 1'b0;
    cyc();
    n_checks++;
    if ({req_ready_o, rsp_valid_o, eng_cfg_o, eng_start_o} !== '0) begin
      n_fail++; $display("FAIL reset_idle: got %h expected 0", {req_ready_o, rsp_valid_o, eng_cfg_o, eng_start_o});
    end
  endtask

  task automatic test_cold_start();
    int cb, sb;
    bit ok;
    cb = n_cfg; sb = n_start;
    res_key = 16'h1234 ^ 16'h0ABC;
    set_req(0, 2'd2, 16'h1234);
    req_valid_i = 4'b0001;
    run_until_rsp(n_rsp + 1, n_grant + 1, 80, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL cold_timeout: got no response expected 1"); end
    n_checks++;
    if (n_cfg - cb !== 1 || last_cfg_func !== 2'd2) begin
      n_fail++; $display("FAIL cold_cfg: got count %0d func %0d expected 1 func 2", n_cfg - cb, last_cfg_func);
    end
    n_checks++;
    if (n_start - sb !== 1 || last_start_data !== 16'h1234) begin
      n_fail++; $display("FAIL cold_start: got count %0d data %h expected 1 data 1234", n_start - sb, last_start_data);
    end
    n_checks++;
    if (ok && (rsp_id_q[$] !== 0 || rsp_data_q[$] !== 16'h0ABC || rsp_err_q[$] !== 1'b0)) begin
      n_fail++; $display("FAIL cold_rsp: got id %0d data %h err %b expected 0 0abc 0", rsp_id_q[$], rsp_data_q[$], rsp_err_q[$]);
    end
  endtask

  task automatic test_bank_reuse();
    int cb;
    bit ok;
    cb = n_cfg;
    res_key = 16'hA5A5;
    set_req(0, 2'd2, 16'h5678);
    req_valid_i = 4'b0001;
    run_until_rsp(n_rsp + 1, n_grant + 1, 60, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL reuse_timeout: got no response expected 1"); end
    n_checks++;
    if (n_cfg - cb !== 0) begin n_fail++; $display("FAIL reuse_cfg: got %0d expected 0", n_cfg - cb); end
    n_checks++;
    if (start_cyc - gnt_cyc_q[$] !== 1) begin
      n_fail++; $display("FAIL reuse_latency: got %0d expected 1", start_cyc - gnt_cyc_q[$]);
    end
    n_checks++;
    if (ok && rsp_data_q[$] !== 16'hF3DD) begin
      n_fail++; $display("FAIL reuse_rsp: got %h expected f3dd", rsp_data_q[$]);
    end
    n_checks++;
    if (eng_data_o !== 16'h5678 || eng_cfg_func_o !== 2'd2) begin
      n_fail++; $display("FAIL reuse_hold: got %h/%0d expected 5678/2", eng_data_o, eng_cfg_func_o);
    end
  endtask

  task automatic test_round_robin();
    int cb, gb, hb;
    bit ok;
    int exp_id[5] = '{0, 1, 2, 3, 0};
    logic [DATA_W-1:0] exp_d[5] = '{16'hA4A5, 16'hA4A4, 16'hA4A7, 16'hA4A6, 16'hA4A5};
    rst_i = 1'b1; cyc(); rst_i = 1'b0; cyc();
    cb = n_cfg; gb = gnt_id_q.size(); hb = hs_cyc_q.size();
    for (int k = 0; k < N_REQ; k++) set_req(k, 2'd1, DATA_W'(16'h0100 + k));
    req_valid_i = 4'b1111;
    run_until_rsp(n_rsp + 5, n_grant + 5, 300, ok);
    cyc();
    n_checks++;
    if (!ok || gnt_id_q.size() - gb !== 5) begin
      n_fail++; $display("FAIL rr_count: got %0d grants expected 5", gnt_id_q.size() - gb);
    end
    if (ok && gnt_id_q.size() - gb >= 5) begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (gnt_id_q[gb+i] !== exp_id[i] || !$onehot(gnt_vec_q[gb+i])) begin
          n_fail++; $display("FAIL rr_grant%0d: got %0d (%b) expected %0d", i, gnt_id_q[gb+i], gnt_vec_q[gb+i], exp_id[i]);
        end
        n_checks++;
        if (rsp_id_q[hb+i] !== exp_id[i] || rsp_data_q[hb+i] !== exp_d[i]) begin
          n_fail++; $display("FAIL rr_rsp%0d: got %0d/%h expected %0d/%h", i, rsp_id_q[hb+i], rsp_data_q[hb+i], exp_id[i], exp_d[i]);
        end
      end
      n_checks++;
      if (gnt_cyc_q[gb+1] - hs_cyc_q[hb] !== 1) begin
        n_fail++; $display("FAIL rr_regrant: got %0d expected 1", gnt_cyc_q[gb+1] - hs_cyc_q[hb]);
      end
    end
    n_checks++;
    if (n_cfg - cb !== 1) begin n_fail++; $display("FAIL rr_cfg: got %0d expected 1", n_cfg - cb); end
  endtask

  task automatic test_timeout();
    int cb;
    bit ok;
    done_en = 1'b0;
    set_req(2, 2'd1, 16'h2222);
    req_valid_i = 4'b0100;
    run_until_rsp(n_rsp + 1, n_grant + 1, 80, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL to_timeout: got no response expected 1"); end
    n_checks++;
    if (ok && (rsp_id_q[$] !== 2 || rsp_data_q[$] !== 16'h0000 || rsp_err_q[$] !== 1'b1)) begin
      n_fail++; $display("FAIL to_rsp: got id %0d data %h err %b expected 2 0000 1", rsp_id_q[$], rsp_data_q[$], rsp_err_q[$]);
    end
    n_checks++;
    if (rsp_first_cyc - start_cyc !== TIMEOUT) begin
      n_fail++; $display("FAIL to_latency: got %0d expected %0d", rsp_first_cyc - start_cyc, TIMEOUT);
    end
    done_en = 1'b1;
    cb = n_cfg;
    set_req(3, 2'd1, 16'h3333);
    req_valid_i = 4'b1000;
    run_until_rsp(n_rsp + 1, n_grant + 1, 80, ok);
    n_checks++;
    if (n_cfg - cb !== 1 || last_cfg_func !== 2'd1) begin
      n_fail++; $display("FAIL to_reload: got %0d func %0d expected 1 func 1", n_cfg - cb, last_cfg_func);
    end
    n_checks++;
    if (!ok || rsp_data_q[$] !== 16'h9696 || rsp_id_q[$] !== 3) begin
      n_fail++; $display("FAIL to_next_rsp: got %h id %0d expected 9696 id 3", rsp_data_q[$], rsp_id_q[$]);
    end
  endtask

  task automatic test_backpressure();
    int gb, rb;
    rsp_ready_i = 1'b0;
    set_req(0, 2'd1, 16'h7777);
    req_valid_i = 4'b0001;
    rb = n_rsp;
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (rsp_valid_o) break;
    end
    n_checks++;
    if (rsp_valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_reach_resp: got %b expected 1", rsp_valid_o); end
    gb = n_grant;
    req_valid_i = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) inj_req++;
      cyc();
      n_checks++;
      if ({rsp_valid_o, rsp_id_o, rsp_data_o, rsp_err_o, req_ready_o} !== {1'b1, 2'd0, 16'hD2D2, 1'b0, 4'b0000}) begin
        n_fail++; $display("FAIL bp_hold%0d: got %h expected %h", i, {rsp_valid_o, rsp_id_o, rsp_data_o, rsp_err_o, req_ready_o},
                           {1'b1, 2'd0, 16'hD2D2, 1'b0, 4'b0000});
      end
    end
    req_valid_i = '0;
    rsp_ready_i = 1'b1;
    cyc();
    rsp_ready_i = 1'b0;
    cyc();
    n_checks++;
    if (n_rsp - rb !== 1 || rsp_data_q[$] !== 16'hD2D2 || n_grant !== gb || rsp_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL bp_release: got %0d rsp data %h grants %0d valid %b expected 1 d2d2 %0d 0",
                         n_rsp - rb, rsp_data_q[$], n_grant, rsp_valid_o, gb);
    end
    rsp_ready_i = 1'b1;
  endtask

  task automatic test_reset_in_wait();
    int gb, sb, rb, cb, qb;
    bit ok;
    done_en = 1'b0;
    gb = n_grant; sb = n_start; rb = n_rsp;
    set_req(1, 2'd1, 16'h4444);
    req_valid_i = 4'b0010;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (n_grant > gb) req_valid_i = '0;
      if (n_start > sb) break;
    end
    n_checks++;
    if (n_start - sb !== 1) begin n_fail++; $display("FAIL rw_start: got %0d expected 1", n_start - sb); end
    cyc(); cyc(); cyc();
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    n_checks++;
    if ({req_ready_o, eng_cfg_o, eng_cfg_func_o, eng_start_o, eng_data_o, rsp_valid_o, rsp_id_o, rsp_data_o, rsp_err_o} !== '0) begin
      n_fail++; $display("FAIL rw_outputs: got %h expected 0",
                         {req_ready_o, eng_cfg_o, eng_cfg_func_o, eng_start_o, eng_data_o, rsp_valid_o, rsp_id_o, rsp_data_o, rsp_err_o});
    end
    for (int i = 0; i < 8; i++) cyc();
    n_checks++;
    if (n_rsp !== rb) begin n_fail++; $display("FAIL rw_no_rsp: got %0d expected %0d", n_rsp, rb); end
    done_en = 1'b1;
    cb = n_cfg; qb = gnt_id_q.size();
    set_req(0, 2'd1, 16'h0F00);
    req_valid_i = 4'b1111;
    run_until_rsp(n_rsp + 1, n_grant + 1, 80, ok);
    n_checks++;
    if (!ok || gnt_id_q[qb] !== 0) begin
      n_fail++; $display("FAIL rw_rrptr: got %0d expected 0", (gnt_id_q.size() > qb) ? gnt_id_q[qb] : -1);
    end
    n_checks++;
    if (n_cfg - cb !== 1) begin n_fail++; $display("FAIL rw_reload: got %0d expected 1", n_cfg - cb); end
    n_checks++;
    if (!ok || rsp_data_q[$] !== 16'hAAA5) begin
      n_fail++; $display("FAIL rw_rsp: got %h expected aaa5", rsp_data_q[$]);
    end
  endtask

  initial begin
    rst_i       = 1'b1;
    req_valid_i = '0;
    req_data_i  = '0;
    req_func_i  = '0;
    rsp_ready_i = 1'b1;
    for (int k = 0; k < N_REQ; k++) set_req(k, 2'd0, DATA_W'(16'h0A00 + k));
    test_reset();
    test_cold_start();
    test_bank_reuse();
    test_round_robin();
    test_timeout();
    test_backpressure();
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
